// File: rtl/issp_target.sv
// Target end of the ISSP serial link for loopback self-test of the programmer.
// Samples host SCLK/SDATA through synchronisers and assembles 22-bit vectors
// MSB-first. Plays the target half of the SDATA handshakes: the power-on
// acknowledge (SDATA low) and the execute busy/ready sequence (high, low, tail).
// Strobes vec_valid, exec_done and err_timeout are single-cycle pulses.
module issp_target #(
    parameter int VEC_BITS       = 22,
    parameter int POR_ACK_CYCLES = 48,
    parameter int BUSY_CYCLES    = 120,
    parameter int TAIL_CLKS      = 50,
    parameter int IDLE_TIMEOUT   = 2400
) (
    input  logic                osc,
    input  logic                rst,
    input  logic                sclk_in,
    input  logic                sdata_in,
    output logic                sdata_out,
    output logic                sdata_oe,
    output logic [VEC_BITS-1:0] vec_data,
    output logic                vec_valid,
    input  logic                exec_req,
    output logic                exec_busy,
    output logic                exec_done,
    output logic                err_timeout,
    output logic [2:0]          dbg_state
);

    localparam int CNT_MAX = (POR_ACK_CYCLES > BUSY_CYCLES) ? POR_ACK_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = $clog2(VEC_BITS + 1);
    localparam int TAIL_W  = $clog2(TAIL_CLKS + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_POR_ACK   = 3'd0,
        ST_RX        = 3'd1,
        ST_EXEC_HI   = 3'd2,
        ST_EXEC_LO   = 3'd3,
        ST_EXEC_TAIL = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [TAIL_W-1:0]   tailcnt_q, tailcnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [VEC_BITS-1:0] shreg_q, shreg_d;
    logic [VEC_BITS-1:0] vec_data_q, vec_data_d;
    logic                pending_q, pending_d;
    logic                sdata_out_q, sdata_out_d;
    logic                sdata_oe_q, sdata_oe_d;
    logic                vec_valid_q, vec_valid_d;
    logic                exec_busy_q, exec_busy_d;
    logic                exec_done_q, exec_done_d;
    logic                err_timeout_q, err_timeout_d;
    logic                sclk_s1_q, sclk_s1_d;
    logic                sclk_s2_q, sclk_s2_d;
    logic                sclk_s3_q, sclk_s3_d;
    logic                sdata_s1_q, sdata_s1_d;
    logic                sdata_s2_q, sdata_s2_d;
    logic                sclk_rise;

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;

    // Next-state logic: synchronisers, handshake FSM, vector assembly and timeout.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bitcnt_d      = bitcnt_q;
        tailcnt_d     = tailcnt_q;
        idle_d        = idle_q;
        shreg_d       = shreg_q;
        vec_data_d    = vec_data_q;
        sdata_out_d   = sdata_out_q;
        sdata_oe_d    = sdata_oe_q;
        vec_valid_d   = 1'b0;
        exec_done_d   = 1'b0;
        err_timeout_d = 1'b0;
        // Requests are latched in every state and only serviced from RX.
        pending_d     = pending_q | exec_req;

        sclk_s1_d  = sclk_in;
        sclk_s2_d  = sclk_s1_q;
        sclk_s3_d  = sclk_s2_q;
        sdata_s1_d = sdata_in;
        sdata_s2_d = sdata_s1_q;

        case (state_q)
            ST_POR_ACK: begin
                sdata_oe_d  = 1'b1;
                sdata_out_d = 1'b0;
                if (cnt_q == '0) begin
                    sdata_oe_d = 1'b0;
                    state_d    = ST_RX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RX: begin
                if (bitcnt_q == BIT_W'(VEC_BITS)) begin
                    // Publish the completed vector; a pending execute waits one more cycle.
                    vec_data_d  = shreg_q;
                    vec_valid_d = 1'b1;
                    bitcnt_d    = '0;
                    idle_d      = '0;
                end else if (pending_q && (bitcnt_q == '0)) begin
                    state_d     = ST_EXEC_HI;
                    sdata_oe_d  = 1'b1;
                    sdata_out_d = 1'b1;
                    cnt_d       = CNT_W'(BUSY_CYCLES - 1);
                    pending_d   = exec_req;
                end else if (sclk_rise) begin
                    shreg_d  = {shreg_q[VEC_BITS-2:0], sdata_s2_q};
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                    idle_d   = '0;
                end else if (bitcnt_q != '0) begin
                    if (idle_q == IDLE_W'(IDLE_TIMEOUT)) begin
                        // Host went quiet mid-vector: drop the partial bits.
                        err_timeout_d = 1'b1;
                        bitcnt_d      = '0;
                        idle_d        = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            ST_EXEC_HI: begin
                if (cnt_q == '0) begin
                    sdata_out_d = 1'b0;
                    state_d     = ST_EXEC_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXEC_LO: begin
                tailcnt_d = '0;
                state_d   = ST_EXEC_TAIL;
            end
            ST_EXEC_TAIL: begin
                if (tailcnt_q == TAIL_W'(TAIL_CLKS)) begin
                    sdata_oe_d  = 1'b0;
                    exec_done_d = 1'b1;
                    bitcnt_d    = '0;
                    idle_d      = '0;
                    state_d     = ST_RX;
                end else if (sclk_rise) begin
                    tailcnt_d = tailcnt_q + TAIL_W'(1);
                end
            end
            default: begin
                state_d = ST_POR_ACK;
            end
        endcase

        // Busy is decoded from the next state so it lines up with the state register.
        exec_busy_d = (state_d == ST_EXEC_HI) || (state_d == ST_EXEC_LO) ||
                      (state_d == ST_EXEC_TAIL);
    end

    // State and output registers with synchronous reset into POR_ACK.
    always_ff @(posedge osc) begin
        if (rst) begin
            state_q       <= ST_POR_ACK;
            cnt_q         <= CNT_W'(POR_ACK_CYCLES - 1);
            bitcnt_q      <= '0;
            tailcnt_q     <= '0;
            idle_q        <= '0;
            shreg_q       <= '0;
            vec_data_q    <= '0;
            pending_q     <= 1'b0;
            sdata_out_q   <= 1'b0;
            sdata_oe_q    <= 1'b1;
            vec_valid_q   <= 1'b0;
            exec_busy_q   <= 1'b0;
            exec_done_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            sclk_s1_q     <= 1'b0;
            sclk_s2_q     <= 1'b0;
            sclk_s3_q     <= 1'b0;
            sdata_s1_q    <= 1'b0;
            sdata_s2_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitcnt_q      <= bitcnt_d;
            tailcnt_q     <= tailcnt_d;
            idle_q        <= idle_d;
            shreg_q       <= shreg_d;
            vec_data_q    <= vec_data_d;
            pending_q     <= pending_d;
            sdata_out_q   <= sdata_out_d;
            sdata_oe_q    <= sdata_oe_d;
            vec_valid_q   <= vec_valid_d;
            exec_busy_q   <= exec_busy_d;
            exec_done_q   <= exec_done_d;
            err_timeout_q <= err_timeout_d;
            sclk_s1_q     <= sclk_s1_d;
            sclk_s2_q     <= sclk_s2_d;
            sclk_s3_q     <= sclk_s3_d;
            sdata_s1_q    <= sdata_s1_d;
            sdata_s2_q    <= sdata_s2_d;
        end
    end

    assign sdata_out   = sdata_out_q;
    assign sdata_oe    = sdata_oe_q;
    assign vec_data    = vec_data_q;
    assign vec_valid   = vec_valid_q;
    assign exec_busy   = exec_busy_q;
    assign exec_done   = exec_done_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_issp_target.sv
// Bench for issp_target: a host model drives SCLK/SDATA bit by bit, a monitor
// scores every strobe against the vectors the host sent and the handshake
// timing derived from the link rules (2-flop sync + edge flop + 1 register).
module tb_issp_target;

    localparam int VEC_BITS     = 22;
    localparam int POR_CYC      = 48;
    localparam int BUSY_CYC     = 120;
    localparam int TAIL_CLKS    = 50;
    localparam int IDLE_TO      = 2400;
    // Pin change to detected rise: two sync flops plus the edge flop.
    localparam int SYNC_LAT     = 3;

    logic                osc = 1'b0;
    logic                rst;
    logic                sclk_in;
    logic                sdata_in;
    logic                exec_req;
    logic                sdata_out;
    logic                sdata_oe;
    logic [VEC_BITS-1:0] vec_data;
    logic                vec_valid;
    logic                exec_busy;
    logic                exec_done;
    logic                err_timeout;
    logic [2:0]          dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int vv_cyc = 0;
    int vec_seen = 0;
    int done_cnt = 0;
    int to_cnt = 0;
    logic prev_vv = 1'b0;
    logic prev_done = 1'b0;
    logic prev_to = 1'b0;

    logic [VEC_BITS-1:0] exp_q[$];

    issp_target dut (
        .osc        (osc),
        .rst        (rst),
        .sclk_in    (sclk_in),
        .sdata_in   (sdata_in),
        .sdata_out  (sdata_out),
        .sdata_oe   (sdata_oe),
        .vec_data   (vec_data),
        .vec_valid  (vec_valid),
        .exec_req   (exec_req),
        .exec_busy  (exec_busy),
        .exec_done  (exec_done),
        .err_timeout(err_timeout),
        .dbg_state  (dbg_state)
    );

    // Clock and cycle counter (24 MHz approximated by a 42 ns period).
    always #21 osc = ~osc;
    always @(posedge osc) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: scores every strobe on the falling edge.
    always @(negedge osc) begin
        prev_vv   <= vec_valid;
        prev_done <= exec_done;
        prev_to   <= err_timeout;
        if (vec_valid === 1'b1) begin
            vec_seen <= vec_seen + 1;
            vv_cyc   <= cyc;
            check_val("vec_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_val("vec_data", 32'(vec_data), 32'(exp_q.pop_front()));
            check_val("vec_latency", 32'(cyc - last_rise_cyc), 32'(SYNC_LAT + 1));
            check_val("vec_pulse", 32'(prev_vv), 32'd0);
        end
        if (exec_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            check_val("done_latency", 32'(cyc - last_rise_cyc), 32'(SYNC_LAT + 1));
            check_val("done_pulse", 32'(prev_done), 32'd0);
        end
        if (err_timeout === 1'b1) begin
            to_cnt <= to_cnt + 1;
            check_val("timeout_latency", 32'(cyc - last_rise_cyc), 32'(SYNC_LAT + IDLE_TO + 1));
            check_val("timeout_pulse", 32'(prev_to), 32'd0);
        end
    end

    // Driver tasks: every drive happens 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge osc);
        #1;
    endtask

    task automatic send_bit(input logic b, input int hp);
        sclk_in  = 1'b0;
        sdata_in = b;
        tick(hp);
        sclk_in       = 1'b1;
        last_rise_cyc = cyc;
        tick(hp);
    endtask

    task automatic send_vec(input logic [VEC_BITS-1:0] v, input int hp);
        exp_q.push_back(v);
        for (int i = VEC_BITS - 1; i >= 0; i--) send_bit(v[i], hp);
    endtask

    task automatic pulse_exec();
        exec_req = 1'b1;
        tick(1);
        exec_req = 1'b0;
    endtask

    // Called right after reset is released: SDATA must be held low for POR_CYC cycles.
    task automatic por_check();
        int n = 0;
        int bad = 0;
        @(negedge osc);
        while (sdata_oe === 1'b1 && n < 300) begin
            if (sdata_out !== 1'b0) bad++;
            n++;
            @(negedge osc);
        end
        check_val("por_length", 32'(n), 32'(POR_CYC));
        check_val("por_low", 32'(bad), 32'd0);
        check_val("por_release", 32'(sdata_oe), 32'd0);
    endtask

    initial begin
        logic [VEC_BITS-1:0] v;
        int n;
        int old;
        int t_hi;
        int t_lo;
        int hp;

        rst      = 1'b1;
        sclk_in  = 1'b0;
        sdata_in = 1'b0;
        exec_req = 1'b0;
        tick(3);
        check_val("rst_vec_data", 32'(vec_data), 32'd0);
        check_val("rst_strobes", {29'd0, vec_valid, exec_done, err_timeout}, 32'd0);
        check_val("rst_busy", 32'(exec_busy), 32'd0);
        check_val("rst_drive", {30'd0, sdata_oe, sdata_out}, 32'd2);
        rst = 1'b0;
        por_check();

        // Single vector at 250 ns half-periods.
        send_vec(22'h2A5C3F, 6);
        tick(10);
        check_val("vec_count_1", 32'(vec_seen), 32'd1);

        // Back-to-back vectors.
        send_vec(22'h3FFFFF, 6);
        send_vec(22'h000001, 6);
        tick(10);
        check_val("vec_count_3", 32'(vec_seen), 32'd3);

        // Partial vector then idle: timeout, then a clean vector.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 6);
        old = to_cnt;
        n = 0;
        while (to_cnt == old && n < 3000) begin
            tick(1);
            n++;
        end
        check_val("timeout_seen", 32'(to_cnt - old), 32'd1);
        check_val("vec_count_to", 32'(vec_seen), 32'd3);
        send_vec(22'h155555, 6);
        tick(10);
        check_val("vec_count_4", 32'(vec_seen), 32'd4);

        // Random vectors with random bit rates and gaps.
        for (int k = 0; k < 6; k++) begin
            v  = VEC_BITS'($urandom);
            hp = $urandom_range(2, 8);
            send_vec(v, hp);
            tick($urandom_range(6, 40));
        end
        check_val("vec_count_rand", 32'(vec_seen), 32'd10);

        // Execute requested after bit 5: the vector completes first.
        v = VEC_BITS'($urandom);
        exp_q.push_back(v);
        for (int i = VEC_BITS - 1; i >= 0; i--) begin
            send_bit(v[i], 4);
            if (i == VEC_BITS - 5) pulse_exec();
        end
        n = 0;
        @(negedge osc);
        while (!(sdata_oe === 1'b1 && sdata_out === 1'b1) && n < 200) begin
            @(negedge osc);
            n++;
        end
        t_hi = cyc;
        check_val("vec_count_exec", 32'(vec_seen), 32'd11);
        check_val("exec_hi_start", 32'(t_hi - vv_cyc), 32'd1);
        check_val("exec_busy_hi", 32'(exec_busy), 32'd1);
        // Rises during the busy phase must not count toward the tail.
        for (int i = 0; i < 3; i++) send_bit(1'b1, 2);
        n = 0;
        @(negedge osc);
        while (sdata_out === 1'b1 && n < 300) begin
            @(negedge osc);
            n++;
        end
        t_lo = cyc;
        check_val("busy_length", 32'(t_lo - t_hi), 32'(BUSY_CYC));
        check_val("exec_lo_drive", {30'd0, sdata_oe, exec_busy}, 32'd3);
        old = done_cnt;
        for (int i = 0; i < TAIL_CLKS - 1; i++) send_bit(1'($urandom_range(0, 1)), 3);
        tick(20);
        check_val("tail49_busy", 32'(exec_busy), 32'd1);
        check_val("tail49_drive", {30'd0, sdata_oe, sdata_out}, 32'd2);
        check_val("tail49_no_done", 32'(done_cnt - old), 32'd0);
        pulse_exec();
        send_bit(1'b0, 3);
        n = 0;
        @(negedge osc);
        while (exec_done !== 1'b1 && n < 100) begin
            @(negedge osc);
            n++;
        end
        check_val("done_release", {30'd0, sdata_oe, exec_busy}, 32'd0);
        @(negedge osc);
        check_val("done_count", 32'(done_cnt - old), 32'd1);
        check_val("relatched_exec", {30'd0, sdata_oe, sdata_out}, 32'd3);
        check_val("relatched_busy", 32'(exec_busy), 32'd1);

        // Reset in the middle of the tail of the second handshake.
        n = 0;
        while (sdata_out === 1'b1 && n < 300) begin
            @(negedge osc);
            n++;
        end
        old = done_cnt;
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 3);
        pulse_exec();
        rst = 1'b1;
        tick(1);
        check_val("rst_tail_busy", 32'(exec_busy), 32'd0);
        check_val("rst_tail_drive", {30'd0, sdata_oe, sdata_out}, 32'd2);
        rst = 1'b0;
        por_check();
        n = 0;
        repeat (300) begin
            @(negedge osc);
            if (sdata_oe === 1'b1 || exec_busy === 1'b1) n++;
        end
        check_val("rst_pending_cleared", 32'(n), 32'd0);
        check_val("rst_no_done", 32'(done_cnt - old), 32'd0);

        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("timeout_total", 32'(to_cnt), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
